// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues pipelined word reads to instruction
// memory and buffers returned words in a small FIFO that feeds the control decoder.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] BUBBLE   = 32'h4400_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] ins,
   output logic [31:0] ins_pc,
   output logic [31:0] ins_pc_plus4,
   output logic        ins_valid,
   input  logic        ins_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1) + 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CAP  = CW'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   wordMem_q [DEPTH];
   logic [31:0]   pcMem_q [DEPTH];
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflightPc_q, inflightPc_d;
   logic          squash_q, squash_d;
   logic          pop;
   logic          push;
   logic          accept;
   logic [CW-1:0] occupancy;

   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign ins_valid    = (count_q != '0);
   assign ins          = ins_valid ? wordMem_q[rdPtr_q] : BUBBLE;
   assign ins_pc       = ins_valid ? pcMem_q[rdPtr_q] : 32'h0;
   assign ins_pc_plus4 = ins_pc + 32'd4;

   // Words already buffered plus the one in flight must still fit after this cycle's pop,
   // so a new request is only issued when its response is guaranteed a free slot.
   assign pop       = ins_valid && ins_ready && !redirect;
   assign push      = inflight_q && !squash_q;
   assign occupancy = count_q + CW'(inflight_q) - CW'(pop);
   assign imem_req  = !reset && !redirect && (occupancy < CAP);
   assign imem_addr = pc_q;
   assign accept    = imem_req && imem_gnt;

   always_comb begin
      pc_d         = pc_q;
      rdPtr_d      = rdPtr_q;
      wrPtr_d      = wrPtr_q;
      count_d      = count_q + CW'(push) - CW'(pop);
      inflight_d   = accept;
      inflightPc_d = accept ? pc_q : inflightPc_q;
      squash_d     = 1'b0;
      if (accept) pc_d = pc_q + 32'd4;
      if (push) wrPtr_d = nextPtr(wrPtr_q);
      if (pop) rdPtr_d = nextPtr(rdPtr_q);
      // A redirect discards everything younger, including a response landing next cycle.
      if (redirect) begin
         pc_d       = {redirect_pc[31:2], 2'b00};
         rdPtr_d    = '0;
         wrPtr_d    = '0;
         count_d    = '0;
         inflight_d = 1'b0;
         squash_d   = inflight_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         rdPtr_q      <= '0;
         wrPtr_q      <= '0;
         count_q      <= '0;
         inflight_q   <= 1'b0;
         inflightPc_q <= 32'h0;
         squash_q     <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         rdPtr_q      <= rdPtr_d;
         wrPtr_q      <= wrPtr_d;
         count_q      <= count_d;
         inflight_q   <= inflight_d;
         inflightPc_q <= inflightPc_d;
         squash_q     <= squash_d;
      end
   end

   // Storage needs no reset: count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         wordMem_q[wrPtr_q] <= imem_rdata;
         pcMem_q[wrPtr_q]   <= inflightPc_q;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a queue-based model of issued-but-not-consumed instructions.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] BUBBLE   = 32'h4400_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b1;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] ins;
   logic [31:0] ins_pc;
   logic [31:0] ins_pc_plus4;
   logic        ins_valid;
   logic        ins_ready = 1'b1;

   int          checks = 0;
   int          errors = 0;
   logic        accPrev;
   logic [31:0] addrPrev;

   typedef struct {
      logic [31:0] pc;
      int          vc;
   } entry_t;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .BUBBLE(BUBBLE)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .ins(ins), .ins_pc(ins_pc), .ins_pc_plus4(ins_pc_plus4),
      .ins_valid(ins_valid), .ins_ready(ins_ready)
   );

   always #5 clk = ~clk;

   // Memory behaves as addr/4 + 0x100, answering exactly one cycle after acceptance;
   // otherwise the read data is junk so any spurious push is visible.
   task automatic applyStimulus();
      accPrev  = imem_req && imem_gnt;
      addrPrev = imem_addr;
      @(posedge clk);
      #1;
      imem_rdata = accPrev ? (addrPrev >> 2) + 32'h100 : $urandom;
   endtask

   task automatic doReset();
      reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b1; ins_ready = 1'b1;
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; imem_gnt = 1'b1; ins_ready = 1'b1; redirect = 1'b0;
      applyStimulus();
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
      checks++; if (ins_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", ins_valid); end
      checks++; if (ins !== BUBBLE) begin errors++; $display("[TB] FAIL reset_ins: got %h expected %h", ins, BUBBLE); end
      checks++; if (ins_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", ins_pc); end
      checks++; if (ins_pc_plus4 !== 32'h4) begin errors++; $display("[TB] FAIL reset_pc4: got %h expected 4", ins_pc_plus4); end
      applyStimulus();
   endtask

   task automatic test_stream();
      logic [31:0] expPc;
      doReset();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         expPc = 32'(4 * (c - 2));
         checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL stream_req c%0d: got %b expected 1", c, imem_req); end
         checks++; if (imem_addr !== 32'(4 * c)) begin errors++; $display("[TB] FAIL stream_addr c%0d: got %h expected %h", c, imem_addr, 32'(4 * c)); end
         checks++; if (ins_valid !== (c >= 2)) begin errors++; $display("[TB] FAIL stream_valid c%0d: got %b expected %b", c, ins_valid, c >= 2); end
         if (c >= 2) begin
            checks++; if (ins_pc !== expPc) begin errors++; $display("[TB] FAIL stream_pc c%0d: got %h expected %h", c, ins_pc, expPc); end
            checks++; if (ins !== (expPc >> 2) + 32'h100) begin errors++; $display("[TB] FAIL stream_ins c%0d: got %h expected %h", c, ins, (expPc >> 2) + 32'h100); end
            checks++; if (ins_pc_plus4 !== expPc + 32'd4) begin errors++; $display("[TB] FAIL stream_pc4 c%0d: got %h expected %h", c, ins_pc_plus4, expPc + 32'd4); end
         end else begin
            checks++; if (ins !== BUBBLE) begin errors++; $display("[TB] FAIL stream_bubble c%0d: got %h expected %h", c, ins, BUBBLE); end
         end
         applyStimulus();
      end
   endtask

   task automatic test_decode_stall();
      int pops = 0;
      logic stalled;
      doReset();
      for (int c = 0; c < 20; c++) begin
         stalled = (c >= 4) && (c <= 8);
         ins_ready = !stalled;
         @(negedge clk);
         checks++; if (imem_req !== !stalled) begin errors++; $display("[TB] FAIL stall_req c%0d: got %b expected %b", c, imem_req, !stalled); end
         if (c >= 2) begin
            checks++; if (ins_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid c%0d: got %b expected 1", c, ins_valid); end
         end
         if (ins_valid && ins_ready) begin
            checks++; if (ins_pc !== 32'(4 * pops)) begin errors++; $display("[TB] FAIL stall_order c%0d: got %h expected %h", c, ins_pc, 32'(4 * pops)); end
            pops++;
         end
         applyStimulus();
      end
      ins_ready = 1'b1;
      checks++; if (pops !== 13) begin errors++; $display("[TB] FAIL stall_pops: got %0d expected 13", pops); end
   endtask

   task automatic test_mem_stall();
      int pops = 0;
      doReset();
      for (int c = 0; c < 14; c++) begin
         imem_gnt = !((c >= 4) && (c <= 6));
         @(negedge clk);
         if (c >= 4 && c <= 7) begin
            checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL mstall_req c%0d: got %b expected 1", c, imem_req); end
            checks++; if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL mstall_addr c%0d: got %h expected 00000010", c, imem_addr); end
         end
         if (c >= 6 && c <= 8) begin
            checks++; if (ins_valid !== 1'b0) begin errors++; $display("[TB] FAIL mstall_gap c%0d: got %b expected 0", c, ins_valid); end
         end
         if (c == 9) begin
            checks++; if (ins_valid !== 1'b1) begin errors++; $display("[TB] FAIL mstall_arrive: got %b expected 1", ins_valid); end
            checks++; if (ins !== 32'h104) begin errors++; $display("[TB] FAIL mstall_word: got %h expected 00000104", ins); end
         end
         if (ins_valid) begin
            checks++; if (ins_pc !== 32'(4 * pops)) begin errors++; $display("[TB] FAIL mstall_order c%0d: got %h expected %h", c, ins_pc, 32'(4 * pops)); end
            pops++;
         end
         applyStimulus();
      end
      imem_gnt = 1'b1;
      checks++; if (pops !== 9) begin errors++; $display("[TB] FAIL mstall_pops: got %0d expected 9", pops); end
   endtask

   task automatic test_redirect();
      doReset();
      for (int c = 0; c < 10; c++) begin
         redirect    = (c == 5);
         redirect_pc = 32'h0000_0203;
         @(negedge clk);
         if (c == 5) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_req_t: got %b expected 0", imem_req); end
         end
         if (c == 6) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL redir_addr_t1: got req %b addr %h expected 1 00000200", imem_req, imem_addr); end
         end
         if (c == 6 || c == 7) begin
            checks++; if (ins_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_gap c%0d: got %b expected 0", c, ins_valid); end
         end
         if (c == 8) begin
            checks++; if (ins_valid !== 1'b1 || ins_pc !== 32'h200) begin errors++; $display("[TB] FAIL redir_first: got valid %b pc %h expected 1 00000200", ins_valid, ins_pc); end
            checks++; if (ins !== 32'h180) begin errors++; $display("[TB] FAIL redir_word: got %h expected 00000180", ins); end
         end
         if (c == 9) begin
            checks++; if (ins_pc !== 32'h204) begin errors++; $display("[TB] FAIL redir_next: got %h expected 00000204", ins_pc); end
         end
         applyStimulus();
      end
      redirect = 1'b0;
   endtask

   task automatic test_wrap();
      doReset();
      for (int c = 0; c < 8; c++) begin
         redirect    = (c == 3);
         redirect_pc = 32'hFFFF_FFFC;
         @(negedge clk);
         if (c == 4) begin
            checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr0: got %h expected fffffffc", imem_addr); end
         end
         if (c == 5) begin
            checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr1: got %h expected 00000000", imem_addr); end
         end
         if (c == 6) begin
            checks++; if (ins_valid !== 1'b1 || ins_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_pc0: got valid %b pc %h expected 1 fffffffc", ins_valid, ins_pc); end
            checks++; if (ins !== 32'h4000_00FF) begin errors++; $display("[TB] FAIL wrap_word0: got %h expected 400000ff", ins); end
            checks++; if (ins_pc_plus4 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc4: got %h expected 00000000", ins_pc_plus4); end
         end
         if (c == 7) begin
            checks++; if (ins_pc !== 32'h0 || ins !== 32'h100) begin errors++; $display("[TB] FAIL wrap_pc1: got pc %h ins %h expected 00000000 00000100", ins_pc, ins); end
         end
         applyStimulus();
      end
      redirect = 1'b0;
   endtask

   task automatic test_reset_mid();
      doReset();
      ins_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         reset = (c == 2);
         if (c == 3) ins_ready = 1'b1;
         @(negedge clk);
         if (c == 2) begin
            checks++; if (ins_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pre: got %b expected 1", ins_valid); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rmid_req: got %b expected 0", imem_req); end
         end
         if (c == 3) begin
            checks++; if (ins_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_flush: got %b expected 0", ins_valid); end
            checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("[TB] FAIL rmid_restart: got req %b addr %h expected 1 %h", imem_req, imem_addr, RESET_PC); end
         end
         if (c == 4) begin
            checks++; if (ins_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_stale: got %b expected 0", ins_valid); end
         end
         if (c == 5) begin
            checks++; if (ins_valid !== 1'b1 || ins_pc !== RESET_PC) begin errors++; $display("[TB] FAIL rmid_first: got valid %b pc %h expected 1 %h", ins_valid, ins_pc, RESET_PC); end
         end
         applyStimulus();
      end
      reset = 1'b0;
      ins_ready = 1'b1;
   endtask

   // Model: every accepted fetch becomes visible two cycles later and leaves in order.
   task automatic test_random();
      entry_t      q[$];
      logic [31:0] expFetch;
      logic [31:0] frontPc;
      logic        expValid, popE, reqE;
      int          occ;
      doReset();
      expFetch = RESET_PC;
      for (int cyc = 0; cyc < 400; cyc++) begin
         imem_gnt    = ($urandom % 4) != 0;
         ins_ready   = ($urandom % 10) < 7;
         redirect    = ($urandom % 20) == 0;
         redirect_pc = $urandom;
         @(negedge clk);
         expValid = (q.size() > 0) && (q[0].vc <= cyc);
         frontPc  = expValid ? q[0].pc : 32'h0;
         popE     = expValid && ins_ready && !redirect;
         occ      = q.size() - (popE ? 1 : 0);
         reqE     = !redirect && (occ < DEPTH);
         checks++; if (ins_valid !== expValid) begin errors++; $display("[TB] FAIL rnd_valid c%0d: got %b expected %b", cyc, ins_valid, expValid); end
         checks++; if (ins_pc !== frontPc) begin errors++; $display("[TB] FAIL rnd_pc c%0d: got %h expected %h", cyc, ins_pc, frontPc); end
         checks++; if (ins !== (expValid ? (frontPc >> 2) + 32'h100 : BUBBLE)) begin errors++; $display("[TB] FAIL rnd_ins c%0d: got %h expected %h", cyc, ins, expValid ? (frontPc >> 2) + 32'h100 : BUBBLE); end
         checks++; if (ins_pc_plus4 !== frontPc + 32'd4) begin errors++; $display("[TB] FAIL rnd_pc4 c%0d: got %h expected %h", cyc, ins_pc_plus4, frontPc + 32'd4); end
         checks++; if (imem_req !== reqE) begin errors++; $display("[TB] FAIL rnd_req c%0d: got %b expected %b", cyc, imem_req, reqE); end
         if (reqE) begin
            checks++; if (imem_addr !== expFetch) begin errors++; $display("[TB] FAIL rnd_addr c%0d: got %h expected %h", cyc, imem_addr, expFetch); end
         end
         if (redirect) begin
            q.delete();
            expFetch = {redirect_pc[31:2], 2'b00};
         end else begin
            if (popE) void'(q.pop_front());
            if (reqE && imem_gnt) begin
               q.push_back('{pc: expFetch, vc: cyc + 2});
               expFetch = expFetch + 32'd4;
            end
         end
         applyStimulus();
      end
      redirect = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_decode_stall();
      test_mem_stall();
      test_redirect();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
